// File: rtl/lcd_timing_gen_if.sv
`default_nettype none
// ============================================================================
//  Module      : lcd_timing_gen_if
//  Description : Pixel-request and panel-output bundle of the LCD raster
//                timing generator. The master side is the generator.
//  Revision    : 1.0  initial release
// ============================================================================
interface lcd_timing_gen_if;
    logic [15:0] pixel_data;
    logic        data_req;
    logic [10:0] pixel_xpos;
    logic [10:0] pixel_ypos;
    logic        lcd_hs;
    logic        lcd_vs;
    logic        lcd_de;
    logic [15:0] lcd_rgb;
    logic        frame_start;

    modport master (
        input  pixel_data,
        output data_req,
        output pixel_xpos,
        output pixel_ypos,
        output lcd_hs,
        output lcd_vs,
        output lcd_de,
        output lcd_rgb,
        output frame_start
    );

    modport slave (
        output pixel_data,
        input  data_req,
        input  pixel_xpos,
        input  pixel_ypos,
        input  lcd_hs,
        input  lcd_vs,
        input  lcd_de,
        input  lcd_rgb,
        input  frame_start
    );
endinterface
`default_nettype wire

// File: rtl/lcd_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module      : lcd_timing_gen
//  Description : RGB LCD raster timing generator (HS/VS/DE, one-cycle-ahead
//                pixel request, frame start pulse). Optional colour-bar test
//                pattern enabled by defining LCD_TEST_PATTERN_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module lcd_timing_gen #(
    parameter int H_SYNC  = 48,
    parameter int H_BACK  = 88,
    parameter int H_DISP  = 800,
    parameter int H_FRONT = 40,
    parameter int V_SYNC  = 3,
    parameter int V_BACK  = 32,
    parameter int V_DISP  = 480,
    parameter int V_FRONT = 13
) (
    input  logic              clk,
    input  logic              rst,
    lcd_timing_gen_if.master  bus
);

    localparam int c_h_total = H_SYNC + H_BACK + H_DISP + H_FRONT;
    localparam int c_v_total = V_SYNC + V_BACK + V_DISP + V_FRONT;
    localparam int c_ha      = H_SYNC + H_BACK;
    localparam int c_va      = V_SYNC + V_BACK;

    localparam logic [10:0] c_h_last      = 11'(c_h_total - 1);
    localparam logic [10:0] c_v_last      = 11'(c_v_total - 1);
    // Requests lead the display window by one pixel clock.
    localparam logic [10:0] c_h_req_start = 11'(c_ha - 1);
    localparam logic [10:0] c_h_req_end   = 11'(c_ha + H_DISP - 1);
    localparam logic [10:0] c_v_req_start = 11'(c_va);
    localparam logic [10:0] c_v_req_end   = 11'(c_va + V_DISP);
    localparam logic [10:0] c_h_sync      = 11'(H_SYNC);
    localparam logic [10:0] c_v_sync      = 11'(V_SYNC);

    logic [10:0] r_h_cnt;
    logic [10:0] r_v_cnt;
    logic        r_de;
    logic        r_hs;
    logic        r_vs;
    logic        r_frame_start;

    logic        w_h_act;
    logic        w_v_act;
    logic        w_data_req;
    logic [10:0] w_xpos;
    logic [10:0] w_ypos;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (r_h_cnt == c_h_last) begin
            r_h_cnt <= '0;
            r_v_cnt <= (r_v_cnt == c_v_last) ? 11'd0 : r_v_cnt + 11'd1;
        end else begin
            r_h_cnt <= r_h_cnt + 11'd1;
        end
    end

    assign w_h_act    = (r_h_cnt >= c_h_req_start) && (r_h_cnt < c_h_req_end);
    assign w_v_act    = (r_v_cnt >= c_v_req_start) && (r_v_cnt < c_v_req_end);
    assign w_data_req = w_h_act && w_v_act;
    assign w_xpos     = w_data_req ? (r_h_cnt - c_h_req_start) : 11'd0;
    assign w_ypos     = w_data_req ? (r_v_cnt - c_v_req_start) : 11'd0;

    // Panel controls share one register stage so they stay mutually aligned.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_de          <= 1'b0;
            r_hs          <= 1'b1;
            r_vs          <= 1'b1;
            r_frame_start <= 1'b0;
        end else begin
            r_de          <= w_data_req;
            r_hs          <= (r_h_cnt >= c_h_sync);
            r_vs          <= (r_v_cnt >= c_v_sync);
            r_frame_start <= (r_h_cnt == 11'd0) && (r_v_cnt == 11'd0);
        end
    end

`ifdef LCD_TEST_PATTERN_EN
    localparam int          c_bar_w_int = ((H_DISP / 8) > 0) ? (H_DISP / 8) : 1;
    localparam logic [10:0] c_bar_w     = 11'(c_bar_w_int);

    logic [10:0] r_col;
    logic [10:0] w_bar_raw;
    logic [2:0]  w_bar;
    logic [15:0] w_bar_rgb;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_col <= '0;
        end else begin
            r_col <= w_xpos;
        end
    end

    assign w_bar_raw = r_col / c_bar_w;
    assign w_bar     = (w_bar_raw > 11'd7) ? 3'd7 : w_bar_raw[2:0];

    always_comb begin
        w_bar_rgb = 16'h0000;
        case (w_bar)
            3'd0:    w_bar_rgb = 16'hFFFF;
            3'd1:    w_bar_rgb = 16'hFFE0;
            3'd2:    w_bar_rgb = 16'h07FF;
            3'd3:    w_bar_rgb = 16'h07E0;
            3'd4:    w_bar_rgb = 16'hF81F;
            3'd5:    w_bar_rgb = 16'hF800;
            3'd6:    w_bar_rgb = 16'h001F;
            default: w_bar_rgb = 16'h0000;
        endcase
    end

    assign bus.lcd_rgb = r_de ? w_bar_rgb : 16'h0000;
`else
    assign bus.lcd_rgb = r_de ? bus.pixel_data : 16'h0000;
`endif

    assign bus.data_req    = w_data_req;
    assign bus.pixel_xpos  = w_xpos;
    assign bus.pixel_ypos  = w_ypos;
    assign bus.lcd_de      = r_de;
    assign bus.lcd_hs      = r_hs;
    assign bus.lcd_vs      = r_vs;
    assign bus.frame_start = r_frame_start;

endmodule
`default_nettype wire

// File: tb/tb_lcd_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lcd_timing_gen
//  Description : Self-checking bench for lcd_timing_gen using a reduced raster
//                (25 x 9 clocks per frame) so several frames fit in a short run.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_lcd_timing_gen;

    localparam int H_SYNC  = 3;
    localparam int H_BACK  = 4;
    localparam int H_DISP  = 16;
    localparam int H_FRONT = 2;
    localparam int V_SYNC  = 2;
    localparam int V_BACK  = 2;
    localparam int V_DISP  = 4;
    localparam int V_FRONT = 1;
    localparam int HT = H_SYNC + H_BACK + H_DISP + H_FRONT;   // 25
    localparam int VT = V_SYNC + V_BACK + V_DISP + V_FRONT;   // 9
    localparam int FT = HT * VT;                              // 225
    localparam int HA = H_SYNC + H_BACK;                      // 7
    localparam int VA = V_SYNC + V_BACK;                      // 4

`ifdef LCD_TEST_PATTERN_EN
    localparam logic [15:0] P1  = 16'hFFFF;
    localparam logic [15:0] P14 = 16'h0000;
    localparam logic [15:0] P15 = 16'h0000;
`else
    localparam logic [15:0] P1  = 16'd1;
    localparam logic [15:0] P14 = 16'd14;
    localparam logic [15:0] P15 = 16'd15;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    lcd_timing_gen_if bus ();

    lcd_timing_gen #(
        .H_SYNC (H_SYNC),
        .H_BACK (H_BACK),
        .H_DISP (H_DISP),
        .H_FRONT(H_FRONT),
        .V_SYNC (V_SYNC),
        .V_BACK (V_BACK),
        .V_DISP (V_DISP),
        .V_FRONT(V_FRONT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int          k;
        bit          req;
        int          x;
        int          y;
        bit          de;
        bit          hs;
        bit          vs;
        bit          fs;
        logic [15:0] rgb;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input int k, input bit req, input int x, input int y,
                           input bit de, input bit hs, input bit vs, input bit fs,
                           input logic [15:0] rgb);
        vec_t v;
        v.k = k; v.req = req; v.x = x; v.y = y;
        v.de = de; v.hs = hs; v.vs = vs; v.fs = fs; v.rgb = rgb;
        vecs.push_back(v);
    endtask

    task automatic check1(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic int h_of(input int idx);
        return idx % HT;
    endfunction

    function automatic int v_of(input int idx);
        return (idx / HT) % VT;
    endfunction

    function automatic bit m_req(input int idx);
        int h = h_of(idx);
        int v = v_of(idx);
        return (h >= HA - 1) && (h < HA + H_DISP - 1) && (v >= VA) && (v < VA + V_DISP);
    endfunction

    function automatic int m_x(input int idx);
        return m_req(idx) ? h_of(idx) - (HA - 1) : 0;
    endfunction

    function automatic int m_y(input int idx);
        return m_req(idx) ? v_of(idx) - VA : 0;
    endfunction

    function automatic logic [15:0] m_rgb(input int idx);
        logic [15:0] bars [8];
        int          b;
        bars = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                 16'hF81F, 16'hF800, 16'h001F, 16'h0000};
        if (!m_req(idx)) return 16'h0000;
`ifdef LCD_TEST_PATTERN_EN
        b = m_x(idx) / (H_DISP / 8);
        if (b > 7) b = 7;
        return bars[b];
`else
        b = 0;
        return 16'(m_x(idx)) | bars[7] | 16'(b);
`endif
    endfunction

    task automatic check_reset_state(input string name);
        check1({name, " data_req"},    int'(bus.data_req),    0);
        check1({name, " lcd_de"},      int'(bus.lcd_de),      0);
        check1({name, " lcd_hs"},      int'(bus.lcd_hs),      1);
        check1({name, " lcd_vs"},      int'(bus.lcd_vs),      1);
        check1({name, " frame_start"}, int'(bus.frame_start), 0);
        check1({name, " lcd_rgb"},     int'(bus.lcd_rgb),     0);
    endtask

    // Runs ncyc clocks from a fresh reset release; k counts edges since release.
    task automatic run_raster(input int ncyc, input string tag);
        bit prev_hs = 1'b1, prev_vs = 1'b1, prev_de = 1'b0;
        int hs_run = 0, vs_run = 0, de_run = 0;
        int last_fs = -1, fs_cnt = 0;
        bit ok;
        for (int k = 1; k <= ncyc; k++) begin
            @(posedge clk);
            #1;
            bus.pixel_data = m_req(k - 1) ? 16'(m_x(k - 1)) : 16'hBEEF;
            #1;
            ok = (bus.data_req    == m_req(k))
              && (int'(bus.pixel_xpos) == m_x(k))
              && (int'(bus.pixel_ypos) == m_y(k))
              && (bus.lcd_de      == m_req(k - 1))
              && (bus.lcd_hs      == (h_of(k - 1) >= H_SYNC))
              && (bus.lcd_vs      == (v_of(k - 1) >= V_SYNC))
              && (bus.frame_start == ((k - 1) % FT == 0))
              && (bus.lcd_rgb     == m_rgb(k - 1));
            checks++;
            if (!ok) begin
                failures++;
                $display("FAIL %s cycle k=%0d actual req=%b x=%0d y=%0d de=%b hs=%b vs=%b fs=%b rgb=%h expected req=%b x=%0d y=%0d de=%b hs=%b vs=%b fs=%b rgb=%h",
                         tag, k, bus.data_req, bus.pixel_xpos, bus.pixel_ypos, bus.lcd_de,
                         bus.lcd_hs, bus.lcd_vs, bus.frame_start, bus.lcd_rgb,
                         m_req(k), m_x(k), m_y(k), m_req(k - 1), h_of(k - 1) >= H_SYNC,
                         v_of(k - 1) >= V_SYNC, (k - 1) % FT == 0, m_rgb(k - 1));
            end

            foreach (vecs[i]) begin
                if (vecs[i].k == k) begin
                    string n;
                    n = $sformatf("%s vec k=%0d", tag, k);
                    check1({n, " req"}, int'(bus.data_req),    int'(vecs[i].req));
                    check1({n, " x"},   int'(bus.pixel_xpos),  vecs[i].x);
                    check1({n, " y"},   int'(bus.pixel_ypos),  vecs[i].y);
                    check1({n, " de"},  int'(bus.lcd_de),      int'(vecs[i].de));
                    check1({n, " hs"},  int'(bus.lcd_hs),      int'(vecs[i].hs));
                    check1({n, " vs"},  int'(bus.lcd_vs),      int'(vecs[i].vs));
                    check1({n, " fs"},  int'(bus.frame_start), int'(vecs[i].fs));
                    check1({n, " rgb"}, int'(bus.lcd_rgb),     int'(vecs[i].rgb));
                end
            end

            if (!bus.lcd_hs) hs_run++;
            else if (!prev_hs) begin
                check1({tag, " hs low width"}, hs_run, H_SYNC);
                hs_run = 0;
            end
            if (!bus.lcd_vs) vs_run++;
            else if (!prev_vs) begin
                check1({tag, " vs low width"}, vs_run, V_SYNC * HT);
                vs_run = 0;
            end
            if (bus.lcd_de) de_run++;
            else if (prev_de) begin
                check1({tag, " de burst length"}, de_run, H_DISP);
                de_run = 0;
            end
            if (bus.frame_start) begin
                if (last_fs >= 0) check1({tag, " frame_start period"}, k - last_fs, FT);
                check1({tag, " fs with hs/vs falling"},
                       int'({prev_hs, prev_vs, bus.lcd_hs, bus.lcd_vs}), 4'b1100);
                last_fs = k;
                fs_cnt++;
            end
            prev_hs = bus.lcd_hs;
            prev_vs = bus.lcd_vs;
            prev_de = bus.lcd_de;
        end
        check1({tag, " frame_start count"}, fs_cnt, (ncyc - 1) / FT + 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        // k, req, x, y, de, hs, vs, fs, rgb -- hand-computed for the reduced raster
        add_vec(  1, 0,  0, 0, 0, 0, 0, 1, 16'h0);
        add_vec(  2, 0,  0, 0, 0, 0, 0, 0, 16'h0);
        add_vec(  3, 0,  0, 0, 0, 0, 0, 0, 16'h0);
        add_vec(  4, 0,  0, 0, 0, 1, 0, 0, 16'h0);
        add_vec( 25, 0,  0, 0, 0, 1, 0, 0, 16'h0);
        add_vec( 26, 0,  0, 0, 0, 0, 0, 0, 16'h0);
        add_vec( 51, 0,  0, 0, 0, 0, 1, 0, 16'h0);
        add_vec(106, 1,  0, 0, 0, 1, 1, 0, 16'h0);
        add_vec(108, 1,  2, 0, 1, 1, 1, 0, P1);
        add_vec(121, 1, 15, 0, 1, 1, 1, 0, P14);
        add_vec(122, 0,  0, 0, 1, 1, 1, 0, P15);
        add_vec(123, 0,  0, 0, 0, 1, 1, 0, 16'h0);
        add_vec(131, 1,  0, 1, 0, 1, 1, 0, 16'h0);
        add_vec(196, 1, 15, 3, 1, 1, 1, 0, P14);
        add_vec(197, 0,  0, 0, 1, 1, 1, 0, P15);
        add_vec(225, 0,  0, 0, 0, 1, 1, 0, 16'h0);
        add_vec(226, 0,  0, 0, 0, 0, 0, 1, 16'h0);

        bus.pixel_data = 16'hBEEF;
        repeat (3) @(posedge clk);
        #1;
        check_reset_state("in reset");

        @(negedge clk);
        rst = 1'b0;
        #1;
        check_reset_state("after release");

        run_raster(3 * FT + 2, "run1");

        // Walk into the middle of active line 1 (v=5, h=10), then reset asynchronously.
        repeat (133) @(posedge clk);
        #1;
        check1("pre-reset data_req", int'(bus.data_req),   1);
        check1("pre-reset lcd_de",   int'(bus.lcd_de),     1);
        check1("pre-reset xpos",     int'(bus.pixel_xpos), 4);
        check1("pre-reset ypos",     int'(bus.pixel_ypos), 1);
        #2;
        rst = 1'b1;
        #1;
        check_reset_state("async reset");
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("held reset");

        @(negedge clk);
        rst = 1'b0;
        #1;
        check_reset_state("re-release");
        run_raster(FT + 2, "run2");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
